song_reader: RTL and testbench

Note sequencer that sits directly downstream of the 128×12 song ROM and upstream of the note player. It steps the ROM address through one of four 32-entry songs and unpacks each `{note[5:0], duration[5:0]}` word. It presents each note to the player with a one-cycle `new_note` strobe, then waits for the player's `note_done` before fetching the next entry. It also handles play/pause, song selection, and end-of-song detection.

---
 rtl/song_reader_if.sv | 31 +++
 rtl/song_reader.sv | 114 +++++++++++
 tb/tb_song_reader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/song_reader_if.sv
// song_reader_if: groups the player-facing and ROM-facing signals of the
// song sequencer.
//   play, song         : control from the user side
//   rom_dout, rom_addr : 128x12 song ROM read port (1-cycle latency)
//   note_done          : completion pulse from the note player
//   new_note, note,
//   duration           : note presentation to the player
//   song_done, busy    : status
// slave = sequencer side, master = environment side.
interface song_reader_if;
  logic        play;
  logic [1:0]  song;
  logic [11:0] rom_dout;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        song_done;
  logic        busy;

  modport slave (
    input  play, song, rom_dout, note_done,
    output rom_addr, new_note, note, duration, song_done, busy
  );

  modport master (
    output play, song, rom_dout, note_done,
    input  rom_addr, new_note, note, duration, song_done, busy
  );
endinterface

// File: rtl/song_reader.sv
// song_reader: steps the ROM address through one of four 32-entry songs,
// unpacks {note, duration} words and hands each note to the player with a
// one-cycle new_note strobe, then waits for note_done before fetching the
// next entry. Handles play/pause, song select and end-of-song.
//   clk, reset : clock, synchronous active-high reset
//   bus        : song_reader_if.slave (see interface for signal list)
module song_reader (
  input  logic          clk,
  input  logic          reset,
  song_reader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  song_q, song_d;
  logic [6:0]  addr_q, addr_d;
  logic [5:0]  note_q, note_d;
  logic [5:0]  dur_q, dur_d;
  logic        new_note_q, new_note_d;
  logic        done_q, done_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    song_d     = song_q;
    addr_d     = addr_q;
    note_d     = note_q;
    dur_d      = dur_q;
    new_note_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.play) begin
          state_d = FETCH;
          // A fresh start or a new song restarts at entry 0; otherwise we
          // were paused and pick up where we left off.
          if (idx_q == 5'd0 || bus.song != song_q) begin
            song_d = bus.song;
            idx_d  = 5'd0;
            addr_d = {bus.song, 5'd0};
          end else begin
            addr_d = {song_q, idx_q};
          end
        end
      end
      FETCH: state_d = WAIT_ROM;
      WAIT_ROM: begin
        if (bus.rom_dout[5:0] == 6'd0) begin
          // Zero duration marks the end of the song.
          done_d  = 1'b1;
          idx_d   = 5'd0;
          state_d = IDLE;
        end else begin
          note_d     = bus.rom_dout[11:6];
          dur_d      = bus.rom_dout[5:0];
          new_note_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.note_done) begin
          if (idx_q == 5'd31) begin
            // Never run into the next song's address range.
            idx_d   = 5'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
            if (bus.play) begin
              state_d = FETCH;
              addr_d  = {song_q, idx_d};
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 5'd0;
      song_q     <= 2'd0;
      addr_q     <= 7'd0;
      note_q     <= 6'd0;
      dur_q      <= 6'd0;
      new_note_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      song_q     <= song_d;
      addr_q     <= addr_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      new_note_q <= new_note_d;
      done_q     <= done_d;
    end
  end

  assign bus.rom_addr  = addr_q;
  assign bus.new_note  = new_note_q;
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.song_done = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_song_reader.sv
module tb_song_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  song_reader_if bus ();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Song ROM model: 1-cycle registered read.
  logic [11:0] rom [128];
  always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;
  int nn_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance on negedges until new_note or song_done, bounded to 8 cycles.
  // Releases note_done after the first edge so it is a one-cycle pulse.
  task automatic wait_evt(output int n, output logic nn, output logic sd, output logic [6:0] a1);
    n = 0; nn = 1'b0; sd = 1'b0; a1 = 7'd0;
    while (!nn && !sd && n < 8) begin
      @(negedge clk);
      bus.note_done = 1'b0;
      n++;
      if (n == 1) a1 = bus.rom_addr;
      nn = bus.new_note;
      sd = bus.song_done;
    end
    if (nn) nn_cnt++;
  endtask

  task automatic start_song(input logic [1:0] s, input int a);
    int n; logic nn, sd; logic [6:0] a1;
    bus.song = s;
    bus.play = 1'b1;
    wait_evt(n, nn, sd, a1);
    chk("start_addr", a1, a);
    chk("start_lat", n, 3);
    chk("start_nn", nn, 1);
    chk("start_note", bus.note, rom[a][11:6]);
    chk("start_dur", bus.duration, rom[a][5:0]);
  endtask

  // Called at the ISSUE negedge; acks in WAIT_DONE and expects entry a next.
  task automatic ack_note(input int a);
    int n; logic nn, sd; logic [6:0] a1;
    @(negedge clk);
    bus.note_done = 1'b1;
    wait_evt(n, nn, sd, a1);
    chk("ack_addr", a1, a);
    chk("ack_gap", n, 3);
    chk("ack_nn", nn, 1);
    chk("ack_note", bus.note, rom[a][11:6]);
    chk("ack_dur", bus.duration, rom[a][5:0]);
  endtask

  task automatic chk_reset_vals();
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_note", bus.note, 0);
    chk("rst_dur", bus.duration, 0);
    chk("rst_nn", bus.new_note, 0);
    chk("rst_sd", bus.song_done, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  initial begin
    int n; logic nn, sd; logic [6:0] a1;
    for (int i = 0; i < 128; i++)
      rom[i] = {6'((i * 5 + 3) % 64), 6'((i % 9) + 1)};
    rom[0]  = {6'd49, 6'd12};
    rom[1]  = {6'd1,  6'd8};
    rom[2]  = {6'd0,  6'd4};   // rest
    rom[28] = {6'd37, 6'd0};   // end marker for song 0
    rom[96] = 12'd0;           // song 3 is empty

    bus.play = 1'b0; bus.song = 2'd0; bus.note_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals();

    // Song 0: first two hand vectors, then through to the marker.
    start_song(2'd0, 0);
    chk("s0_note0", bus.note, 49);
    chk("s0_dur0", bus.duration, 12);
    ack_note(1);
    chk("s0_note1", bus.note, 1);
    chk("s0_dur1", bus.duration, 8);
    for (int a = 2; a <= 27; a++) ack_note(a);
    @(negedge clk);
    bus.note_done = 1'b1;
    wait_evt(n, nn, sd, a1);
    bus.play = 1'b0;
    chk("mk_addr", a1, 28);
    chk("mk_lat", n, 3);
    chk("mk_sd", sd, 1);
    chk("mk_nn", nn, 0);
    chk("mk_busy", bus.busy, 0);
    @(negedge clk);
    chk("mk_sd_pulse", bus.song_done, 0);

    // Restart at 0 shows idx was cleared; then pause at idx 5.
    start_song(2'd0, 0);
    for (int a = 1; a <= 5; a++) ack_note(a);
    bus.play = 1'b0;
    @(negedge clk);
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    chk("pause_busy", bus.busy, 0);
    chk("pause_sd", bus.song_done, 0);
    chk("pause_nn", bus.new_note, 0);
    // stray note_done in IDLE
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    @(negedge clk);
    chk("idle_stray_busy", bus.busy, 0);
    start_song(2'd0, 6);        // resume
    bus.play = 1'b0;
    @(negedge clk);
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    chk("pause2_busy", bus.busy, 0);
    start_song(2'd2, 64);       // song changed -> restart

    // Stray note_done in ISSUE is dropped, then reset from WAIT_DONE.
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    chk("iss_stray_nn", bus.new_note, 0);
    chk("iss_stray_busy", bus.busy, 1);
    @(negedge clk);
    chk("iss_stray_hold", bus.busy, 1);
    chk("iss_stray_addr", bus.rom_addr, 64);
    reset = 1'b1;
    bus.play = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    @(negedge clk);

    // Song 3: immediate end marker.
    nn_cnt = 0;
    bus.song = 2'd3;
    bus.play = 1'b1;
    wait_evt(n, nn, sd, a1);
    bus.play = 1'b0;
    chk("s3_addr", a1, 96);
    chk("s3_lat", n, 3);
    chk("s3_sd", sd, 1);
    chk("s3_nn", nn_cnt, 0);
    chk("s3_busy", bus.busy, 0);
    @(negedge clk);

    // Song 1: full 32-entry run, wrap ends the song.
    nn_cnt = 0;
    start_song(2'd1, 32);
    for (int a = 33; a <= 63; a++) ack_note(a);
    @(negedge clk);
    bus.note_done = 1'b1;
    wait_evt(n, nn, sd, a1);
    bus.play = 1'b0;
    chk("wrap_lat", n, 1);
    chk("wrap_sd", sd, 1);
    chk("wrap_nn", nn, 0);
    chk("wrap_busy", bus.busy, 0);
    chk("wrap_count", nn_cnt, 32);
    @(negedge clk);
    chk("wrap_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
